ctrl_pipe_unit: RTL and testbench



---
 rtl/ctrl_pkg.sv | 57 +++++
 rtl/ctrl_decode.sv | 115 +++++++++++
 rtl/ctrl_pipe_unit.sv | 163 ++++++++++++++++
 tb/tb_ctrl_pipe_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared constants and types for the pipeline control unit
package ctrl_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;
  // jr is an R-type funct; it is remapped onto this spare opcode so it decodes
  // in the same case statement as the real opcodes.
  localparam logic [5:0] OP_JR    = 6'h18;

  // R-type funct codes
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_COMPARE
  } alu_fun_e;

  // Polarity of the active-low strobes (REG_RD, MEM_RD, MEM_WR, REG_WR)
  localparam logic ACTIVO    = 1'b0;
  localparam logic DESACTIVO = 1'b1;

  // Bundle widths; the EXE bundle width follows the ALU code width
  localparam int MEM_W = 3;
  localparam int WB_W  = 2;

  // Bubble bundles: nothing is read, written or committed
  localparam logic [MEM_W-1:0] MEM_BUBBLE = {DESACTIVO, DESACTIVO, 1'b1};
  localparam logic [WB_W-1:0]  WB_BUBBLE  = {1'b1, DESACTIVO};

  typedef enum logic [1:0] {
    DIR_PC4 = 2'b00, DIR_J = 2'b01, DIR_JR = 2'b10, DIR_BR = 2'b11
  } sel_dir_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00, BR_BEQ = 2'b01, BR_BNE = 2'b10
  } br_kind_e;

  function automatic int exe_w(input int alu_w);
    return alu_w + 2;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational instruction to control-bundle decoder
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int RA_W  = 5,
  parameter int ALU_W = 3,
  parameter int BR_EN = 1
) (
  input  logic [5:0]                opcode,
  input  logic [5:0]                funct,
  input  logic [RA_W-1:0]           rt,
  input  logic [RA_W-1:0]           rd,
  output logic [exe_w(ALU_W)-1:0]   exe,
  output logic [MEM_W-1:0]          mem,
  output logic [WB_W-1:0]           wb,
  output logic [RA_W-1:0]           wa,
  output logic                      reg_rd,
  output logic                      sel_im,
  output br_kind_e                  br_kind,
  output logic                      is_load,
  output logic                      is_j,
  output logic                      is_jr,
  output logic                      rs_src,
  output logic                      rt_src
);

  logic [5:0]       op_eff;
  logic [ALU_W-1:0] alu;
  logic             sel_alu;
  logic             sel_reg;

  assign op_eff = (opcode == OP_RTYPE && funct == FN_JR) ? OP_JR : opcode;

  // Decode table; anything unrecognised leaves the bubble defaults in place
  always_comb begin
    alu     = ALU_W'(ALU_ADD);
    sel_alu = 1'b0;
    sel_reg = 1'b0;
    mem     = MEM_BUBBLE;
    wb      = WB_BUBBLE;
    reg_rd  = DESACTIVO;
    sel_im  = 1'b0;
    br_kind = BR_NONE;
    is_load = 1'b0;
    is_j    = 1'b0;
    is_jr   = 1'b0;
    rs_src  = 1'b1;
    rt_src  = 1'b0;
    case (op_eff)
      OP_RTYPE: begin
        rt_src  = 1'b1;
        reg_rd  = ACTIVO;
        sel_reg = 1'b1;
        wb      = {1'b1, ACTIVO};
        case (funct)
          FN_ADD:  alu = ALU_W'(ALU_ADD);
          FN_SUB:  alu = ALU_W'(ALU_SUB);
          FN_AND:  alu = ALU_W'(ALU_AND);
          FN_OR:   alu = ALU_W'(ALU_OR);
          FN_NOR:  alu = ALU_W'(ALU_NOR);
          FN_SLT:  alu = ALU_W'(ALU_COMPARE);
          default: begin
            sel_reg = 1'b0;
            wb      = WB_BUBBLE;
          end
        endcase
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
        sel_alu = 1'b1;
        reg_rd  = ACTIVO;
        wb      = {1'b1, ACTIVO};
        case (op_eff)
          OP_SLTI: alu = ALU_W'(ALU_COMPARE);
          OP_ANDI: begin alu = ALU_W'(ALU_AND); sel_im = 1'b1; end
          OP_ORI:  begin alu = ALU_W'(ALU_OR);  sel_im = 1'b1; end
          default: alu = ALU_W'(ALU_ADD);
        endcase
      end
      OP_LW: begin
        sel_alu = 1'b1;
        reg_rd  = ACTIVO;
        mem     = {ACTIVO, DESACTIVO, 1'b1};
        wb      = {1'b0, ACTIVO};
        is_load = 1'b1;
      end
      OP_SW, OP_SH: begin
        sel_alu = 1'b1;
        reg_rd  = ACTIVO;
        rt_src  = 1'b1;
        mem     = {DESACTIVO, ACTIVO, (op_eff == OP_SW)};
      end
      OP_J: begin
        is_j   = 1'b1;
        rs_src = 1'b0;
      end
      OP_JR: begin
        is_jr  = 1'b1;
        reg_rd = ACTIVO;
      end
      OP_BEQ, OP_BNE: begin
        if (BR_EN != 0) begin
          alu     = ALU_W'(ALU_SUB);
          reg_rd  = ACTIVO;
          rt_src  = 1'b1;
          br_kind = (op_eff == OP_BEQ) ? BR_BEQ : BR_BNE;
        end
      end
      default: ;
    endcase
  end

  assign exe = {alu, sel_alu, sel_reg};
  assign wa  = sel_reg ? rd : rt;

endmodule

// File: rtl/ctrl_pipe_unit.sv
// rtl/ctrl_pipe_unit.sv - pipelined control with hazard resolution and event counters
module ctrl_pipe_unit
  import ctrl_pkg::*;
#(
  parameter int RA_W  = 5,
  parameter int ALU_W = 3,
  parameter int BR_EN = 1,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [5:0]              opcode,
  input  logic [5:0]              funct,
  input  logic [RA_W-1:0]         rs,
  input  logic [RA_W-1:0]         rt,
  input  logic [RA_W-1:0]         rd,
  input  logic                    zero_exe,
  input  logic                    stall_ext,
  output logic [1:0]              SEL_DIR,
  output logic                    pc_wr,
  output logic                    ifid_wr,
  output logic                    resetIF,
  output logic                    REG_RD,
  output logic                    SEL_IM,
  output logic [ALU_W+1:0]        ctrl_EXE,
  output logic [MEM_W-1:0]        ctrl_MEM,
  output logic [WB_W-1:0]         ctrl_WB,
  output logic [RA_W-1:0]         wa_mem,
  output logic [RA_W-1:0]         wa_wb,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        flush_cnt
);

  logic [ALU_W+1:0] id_exe;
  logic [MEM_W-1:0] id_mem;
  logic [WB_W-1:0]  id_wb;
  logic [RA_W-1:0]  id_wa;
  br_kind_e         id_br;
  logic             id_load, id_j, id_jr, id_rs_src, id_rt_src;

  // ID/EX keeps the branch kind and load flag alongside the visible bundle
  logic [ALU_W+1:0] idex_exe;
  logic [MEM_W-1:0] idex_mem;
  logic [WB_W-1:0]  idex_wb;
  logic [RA_W-1:0]  idex_wa;
  br_kind_e         idex_br;
  logic             idex_load;
  logic [MEM_W-1:0] exmem_mem;
  logic [WB_W-1:0]  exmem_wb;
  logic [RA_W-1:0]  exmem_wa;
  logic [WB_W-1:0]  memwb_wb;
  logic [RA_W-1:0]  memwb_wa;

  logic br_taken, load_use, kill_id, jump_go;

  ctrl_decode #(.RA_W(RA_W), .ALU_W(ALU_W), .BR_EN(BR_EN)) u_decode (
    .opcode  (opcode),
    .funct   (funct),
    .rt      (rt),
    .rd      (rd),
    .exe     (id_exe),
    .mem     (id_mem),
    .wb      (id_wb),
    .wa      (id_wa),
    .reg_rd  (REG_RD),
    .sel_im  (SEL_IM),
    .br_kind (id_br),
    .is_load (id_load),
    .is_j    (id_j),
    .is_jr   (id_jr),
    .rs_src  (id_rs_src),
    .rt_src  (id_rt_src)
  );

  assign br_taken = (idex_br == BR_BEQ && zero_exe) || (idex_br == BR_BNE && !zero_exe);
  assign load_use = idex_load && (idex_wa != '0) &&
                    ((id_rs_src && rs == idex_wa) || (id_rt_src && rt == idex_wa));
  // The ID slot is discarded by a taken branch (wrong path) or held by load-use
  assign kill_id  = br_taken || load_use;
  assign jump_go  = (id_j || id_jr) && !kill_id;

  // Next-PC and IF/ID steering, in priority order freeze > branch > load-use > jump
  always_comb begin
    SEL_DIR = DIR_PC4;
    pc_wr   = 1'b1;
    ifid_wr = 1'b1;
    resetIF = 1'b0;
    if (stall_ext) begin
      pc_wr   = 1'b0;
      ifid_wr = 1'b0;
    end else if (br_taken) begin
      SEL_DIR = DIR_BR;
      resetIF = 1'b1;
    end else if (load_use) begin
      pc_wr   = 1'b0;
      ifid_wr = 1'b0;
    end else if (id_j) begin
      SEL_DIR = DIR_J;
      resetIF = 1'b1;
    end else if (id_jr) begin
      SEL_DIR = DIR_JR;
      resetIF = 1'b1;
    end
  end

  // Stage registers advance together unless memory freezes the pipe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex_exe  <= '0;
      idex_mem  <= MEM_BUBBLE;
      idex_wb   <= WB_BUBBLE;
      idex_wa   <= '0;
      idex_br   <= BR_NONE;
      idex_load <= 1'b0;
      exmem_mem <= MEM_BUBBLE;
      exmem_wb  <= WB_BUBBLE;
      exmem_wa  <= '0;
      memwb_wb  <= WB_BUBBLE;
      memwb_wa  <= '0;
    end else if (!stall_ext) begin
      if (kill_id) begin
        idex_exe  <= '0;
        idex_mem  <= MEM_BUBBLE;
        idex_wb   <= WB_BUBBLE;
        idex_wa   <= '0;
        idex_br   <= BR_NONE;
        idex_load <= 1'b0;
      end else begin
        idex_exe  <= id_exe;
        idex_mem  <= id_mem;
        idex_wb   <= id_wb;
        idex_wa   <= id_wa;
        idex_br   <= id_br;
        idex_load <= id_load;
      end
      exmem_mem <= idex_mem;
      exmem_wb  <= idex_wb;
      exmem_wa  <= idex_wa;
      memwb_wb  <= exmem_wb;
      memwb_wa  <= exmem_wa;
    end
  end

  // Saturating stall/flush event counters; frozen cycles are not counted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!stall_ext) begin
      if (load_use && !br_taken && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if ((br_taken || jump_go) && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign ctrl_EXE = idex_exe;
  assign ctrl_MEM = exmem_mem;
  assign wa_mem   = exmem_wa;
  assign ctrl_WB  = memwb_wb;
  assign wa_wb    = memwb_wa;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// tb/tb_ctrl_pipe_unit.sv - self-checking bench for ctrl_pipe_unit
module tb_ctrl_pipe_unit;

  localparam int K_BUB = 0, K_ADD = 1, K_SUB = 2, K_AND = 3, K_OR = 4, K_NOR = 5,
                 K_SLT = 6, K_ADDI = 7, K_ANDI = 8, K_ORI = 9, K_SLTI = 10, K_LW = 11,
                 K_SW = 12, K_SH = 13, K_J = 14, K_JR = 15, K_BEQ = 16, K_BNE = 17,
                 NK = 18;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd;
  logic       zero_exe, stall_ext;
  logic [1:0] SEL_DIR;
  logic       pc_wr, ifid_wr, resetIF, REG_RD, SEL_IM;
  logic [4:0] ctrl_EXE;
  logic [2:0] ctrl_MEM;
  logic [1:0] ctrl_WB;
  logic [4:0] wa_mem, wa_wb;
  logic [15:0] stall_cnt, flush_cnt;

  logic [1:0] s_sel_dir;
  logic       s_pc_wr, s_ifid_wr, s_reset_if, s_reg_rd, s_sel_im;
  logic [4:0] s_exe;
  logic [2:0] s_mem;
  logic [1:0] s_wb;
  logic [4:0] s_wa_mem, s_wa_wb;
  logic [1:0] s_stall_cnt, s_flush_cnt;

  always #5 clk = ~clk;

  ctrl_pipe_unit #(.RA_W(5), .ALU_W(3), .BR_EN(1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd),
    .zero_exe(zero_exe), .stall_ext(stall_ext), .SEL_DIR(SEL_DIR), .pc_wr(pc_wr),
    .ifid_wr(ifid_wr), .resetIF(resetIF), .REG_RD(REG_RD), .SEL_IM(SEL_IM),
    .ctrl_EXE(ctrl_EXE), .ctrl_MEM(ctrl_MEM), .ctrl_WB(ctrl_WB), .wa_mem(wa_mem),
    .wa_wb(wa_wb), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  ctrl_pipe_unit #(.RA_W(5), .ALU_W(3), .BR_EN(1), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd),
    .zero_exe(zero_exe), .stall_ext(stall_ext), .SEL_DIR(s_sel_dir), .pc_wr(s_pc_wr),
    .ifid_wr(s_ifid_wr), .resetIF(s_reset_if), .REG_RD(s_reg_rd), .SEL_IM(s_sel_im),
    .ctrl_EXE(s_exe), .ctrl_MEM(s_mem), .ctrl_WB(s_wb), .wa_mem(s_wa_mem),
    .wa_wb(s_wa_wb), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  // Decode vector table: instruction encoding -> expected bundle fields
  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] exe;
    logic [2:0] mem;
    logic [1:0] wb;
    logic       reg_rd;
    logic       sel_im;
  } dec_row_t;
  dec_row_t tab [NK];

  // Reference pipe: which instruction kind sits in each stage and its write address
  typedef struct {
    int         kind;
    logic [4:0] wa;
  } stage_t;
  stage_t m_exe, m_mem, m_wb;
  int m_stall, m_flush;
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_exe = '{K_BUB, 5'd0};
    m_mem = '{K_BUB, 5'd0};
    m_wb  = '{K_BUB, 5'd0};
    m_stall = 0;
    m_flush = 0;
  endtask

  task automatic check_regs();
    chk("ctrl_EXE", 32'(ctrl_EXE), 32'(tab[m_exe.kind].exe));
    chk("ctrl_MEM", 32'(ctrl_MEM), 32'(tab[m_mem.kind].mem));
    chk("wa_mem", 32'(wa_mem), 32'(m_mem.wa));
    chk("ctrl_WB", 32'(ctrl_WB), 32'(tab[m_wb.kind].wb));
    chk("wa_wb", 32'(wa_wb), 32'(m_wb.wa));
    chk("stall_cnt", 32'(stall_cnt), 32'(sat(m_stall, 65535)));
    chk("flush_cnt", 32'(flush_cnt), 32'(sat(m_flush, 65535)));
    chk("sat_stall_cnt", 32'(s_stall_cnt), 32'(sat(m_stall, 3)));
    chk("sat_flush_cnt", 32'(s_flush_cnt), 32'(sat(m_flush, 3)));
  endtask

  // One ID cycle: drive at negedge, check combinational outputs, clock, check registers
  task automatic step(input int k, input logic [4:0] rs_i, input logic [4:0] rt_i,
                      input logic [4:0] rd_i, input logic z, input logic sx);
    logic       taken, lu, reads_rt, is_jump;
    logic [1:0] e_dir;
    logic       e_pc, e_rif;
    opcode = tab[k].op;
    funct  = tab[k].fn;
    rs = rs_i; rt = rt_i; rd = rd_i;
    zero_exe = z;
    stall_ext = sx;
    taken    = (m_exe.kind == K_BEQ && z) || (m_exe.kind == K_BNE && !z);
    reads_rt = k inside {[K_ADD:K_SLT], K_SW, K_SH, K_BEQ, K_BNE};
    lu       = (m_exe.kind == K_LW) && (m_exe.wa != 0) &&
               ((k != K_J && rs_i == m_exe.wa) || (reads_rt && rt_i == m_exe.wa));
    is_jump  = (k == K_J) || (k == K_JR);
    if (sx)              begin e_dir = 2'b00; e_pc = 1'b0; e_rif = 1'b0; end
    else if (taken)      begin e_dir = 2'b11; e_pc = 1'b1; e_rif = 1'b1; end
    else if (lu)         begin e_dir = 2'b00; e_pc = 1'b0; e_rif = 1'b0; end
    else if (k == K_J)   begin e_dir = 2'b01; e_pc = 1'b1; e_rif = 1'b1; end
    else if (k == K_JR)  begin e_dir = 2'b10; e_pc = 1'b1; e_rif = 1'b1; end
    else                 begin e_dir = 2'b00; e_pc = 1'b1; e_rif = 1'b0; end
    #1;
    chk("SEL_DIR", 32'(SEL_DIR), 32'(e_dir));
    chk("pc_wr", 32'(pc_wr), 32'(e_pc));
    chk("ifid_wr", 32'(ifid_wr), 32'(e_pc));
    chk("resetIF", 32'(resetIF), 32'(e_rif));
    chk("REG_RD", 32'(REG_RD), 32'(tab[k].reg_rd));
    chk("SEL_IM", 32'(SEL_IM), 32'(tab[k].sel_im));
    @(posedge clk);
    @(negedge clk);
    if (!sx) begin
      if (!taken && lu) m_stall++;
      if (taken || (!lu && is_jump)) m_flush++;
      m_wb  = m_mem;
      m_mem = m_exe;
      if (taken || lu) m_exe = '{K_BUB, 5'd0};
      else             m_exe = '{k, tab[k].exe[0] ? rd_i : rt_i};
    end
    check_regs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    tab[K_BUB]  = '{6'h3F, 6'h00, 5'b00000, 3'b111, 2'b11, 1'b1, 1'b0};
    tab[K_ADD]  = '{6'h00, 6'h20, 5'b00001, 3'b111, 2'b10, 1'b0, 1'b0};
    tab[K_SUB]  = '{6'h00, 6'h22, 5'b00101, 3'b111, 2'b10, 1'b0, 1'b0};
    tab[K_AND]  = '{6'h00, 6'h24, 5'b01001, 3'b111, 2'b10, 1'b0, 1'b0};
    tab[K_OR]   = '{6'h00, 6'h25, 5'b01101, 3'b111, 2'b10, 1'b0, 1'b0};
    tab[K_NOR]  = '{6'h00, 6'h27, 5'b10001, 3'b111, 2'b10, 1'b0, 1'b0};
    tab[K_SLT]  = '{6'h00, 6'h2A, 5'b10101, 3'b111, 2'b10, 1'b0, 1'b0};
    tab[K_ADDI] = '{6'h08, 6'h00, 5'b00010, 3'b111, 2'b10, 1'b0, 1'b0};
    tab[K_ANDI] = '{6'h0C, 6'h00, 5'b01010, 3'b111, 2'b10, 1'b0, 1'b1};
    tab[K_ORI]  = '{6'h0D, 6'h00, 5'b01110, 3'b111, 2'b10, 1'b0, 1'b1};
    tab[K_SLTI] = '{6'h0A, 6'h00, 5'b10110, 3'b111, 2'b10, 1'b0, 1'b0};
    tab[K_LW]   = '{6'h23, 6'h00, 5'b00010, 3'b011, 2'b00, 1'b0, 1'b0};
    tab[K_SW]   = '{6'h2B, 6'h00, 5'b00010, 3'b101, 2'b11, 1'b0, 1'b0};
    tab[K_SH]   = '{6'h29, 6'h00, 5'b00010, 3'b100, 2'b11, 1'b0, 1'b0};
    tab[K_J]    = '{6'h02, 6'h00, 5'b00000, 3'b111, 2'b11, 1'b1, 1'b0};
    tab[K_JR]   = '{6'h00, 6'h08, 5'b00000, 3'b111, 2'b11, 1'b0, 1'b0};
    tab[K_BEQ]  = '{6'h04, 6'h00, 5'b00100, 3'b111, 2'b11, 1'b0, 1'b0};
    tab[K_BNE]  = '{6'h05, 6'h00, 5'b00100, 3'b111, 2'b11, 1'b0, 1'b0};

    reset = 1'b1;
    opcode = 6'h3F; funct = 6'h00; rs = 5'd0; rt = 5'd0; rd = 5'd0;
    zero_exe = 1'b0; stall_ext = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl_EXE", 32'(ctrl_EXE), 32'h0);
    chk("reset_ctrl_MEM", 32'(ctrl_MEM), 32'h7);
    chk("reset_ctrl_WB", 32'(ctrl_WB), 32'h3);
    chk("reset_wa", 32'({wa_mem, wa_wb}), 32'h0);
    chk("reset_cnts", 32'({stall_cnt, flush_cnt}), 32'h0);
    reset = 1'b0;

    // Load-use: lw $8 then add $9,$8,$1
    step(K_LW, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0);
    step(K_ADD, 5'd8, 5'd1, 5'd9, 1'b0, 1'b0);
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    chk("lu_bubble_exe", 32'(ctrl_EXE), 32'h0);
    step(K_ADD, 5'd8, 5'd1, 5'd9, 1'b0, 1'b0);
    chk("lu_add_issues", 32'(ctrl_EXE), 32'h01);
    chk("lu_bubble_mem", 32'(ctrl_MEM), 32'h7);

    // lw $0 never stalls
    step(K_LW, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
    step(K_ADD, 5'd0, 5'd2, 5'd3, 1'b0, 1'b0);
    chk("zero_no_stall", 32'(stall_cnt), 32'd1);

    // Branch taken / not taken
    step(K_BEQ, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
    step(K_ADD, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
    chk("beq_taken_flush", 32'(flush_cnt), 32'd1);
    step(K_BEQ, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
    step(K_ADD, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    chk("beq_not_taken", 32'(flush_cnt), 32'd1);

    // Taken bne squashes a j in ID; counted once
    step(K_BNE, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
    step(K_J, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("br_over_j", 32'(flush_cnt), 32'd2);

    // Freeze for 3 cycles in an add -> lw -> sw sequence
    step(K_ADD, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    step(K_LW, 5'd1, 5'd4, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(K_SW, 5'd5, 5'd6, 5'd0, 1'b0, 1'b1);
    chk("freeze_exe_lw", 32'(ctrl_EXE), 32'h02);
    step(K_SW, 5'd5, 5'd6, 5'd0, 1'b0, 1'b0);

    // Whole decode table, hazard-free ordering
    for (int k = 0; k < NK; k++) begin
      logic [4:0] r_s, r_t, r_d;
      r_s = (k == K_BUB) ? 5'd0 : 5'd1;
      r_t = (k == K_BUB || k == K_J || k == K_JR) ? 5'd0 : ((k == K_LW) ? 5'd4 : 5'd2);
      r_d = (k == K_BUB || k == K_J || k == K_JR) ? 5'd0 : 5'd3;
      step(k, r_s, r_t, r_d, (m_exe.kind == K_BNE), 1'b0);
    end

    // Random traffic against the reference pipe
    for (int n = 0; n < 600; n++) begin
      int k;
      logic [4:0] r_s, r_t, r_d;
      k   = $urandom_range(0, NK - 1);
      r_s = 5'($urandom_range(0, 3));
      r_t = 5'($urandom_range(0, 3));
      r_d = 5'($urandom_range(0, 3));
      if (k == K_BUB) r_s = 5'd0;
      if (k == K_BUB || k == K_J || k == K_JR) begin r_t = 5'd0; r_d = 5'd0; end
      step(k, r_s, r_t, r_d, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end

    // Asynchronous reset while a load-use stall is active
    step(K_LW, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0);
    opcode = tab[K_ADD].op; funct = tab[K_ADD].fn;
    rs = 5'd8; rt = 5'd1; rd = 5'd9; zero_exe = 1'b0; stall_ext = 1'b0;
    #1;
    chk("pre_reset_stall", 32'(pc_wr), 32'd0);
    reset = 1'b1;
    #1;
    chk("async_rst_exe", 32'(ctrl_EXE), 32'h0);
    chk("async_rst_mem", 32'(ctrl_MEM), 32'h7);
    chk("async_rst_wb", 32'(ctrl_WB), 32'h3);
    chk("async_rst_cnt", 32'({stall_cnt, flush_cnt}), 32'h0);
    chk("async_rst_pc_wr", 32'(pc_wr), 32'd1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Five load-use stalls: 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      step(K_LW, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0);
      step(K_ADD, 5'd8, 5'd1, 5'd9, 1'b0, 1'b0);
    end
    chk("sat_cnt2", 32'(s_stall_cnt), 32'd3);
    chk("sat_cnt16", 32'(stall_cnt), 32'd5);

    do_reset();
    check_regs();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
